swi_debouncer: RTL
==================

SWI_DEBOUNCER -- requirements
Module: swi_debouncer

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, giving the width of the switch bank.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, giving the number of consecutive clk_2 edges a synchronized input must differ before it is accepted (legal range 1..255).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, giving the NBITS-wide value loaded into swi_clean on reset.
REQ-004 The block SHALL have port clk_2, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port swi_raw, input, NBITS: asynchronous, bouncing switch levels.
REQ-007 The block SHALL have port swi_clean, output, NBITS: debounced, registered switch levels, suitable to drive SWI of the display logic.
REQ-008 The block SHALL have port rise, output, NBITS: one-cycle pulse per bit when swi_clean goes 0->1.
REQ-009 The block SHALL have port fall, output, NBITS: one-cycle pulse per bit when swi_clean goes 1->0.
REQ-010 The block SHALL have port changed, output, 1 bit: registered OR-reduction of rise|fall, asserted in the same cycle as the pulses.

Function
REQ-011 Each bit SHALL pass through a two-flop synchronizer (s1 then s2) before any other use; no logic SHALL sit between s1 and s2.
REQ-012 Each bit SHALL own an independent counter cnt of width $clog2(STABLE_CYCLES+1).
REQ-013 On an edge where s2 == swi_clean, that bit's cnt SHALL load 0.
REQ-014 On an edge where s2 != swi_clean and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1.
REQ-015 On an edge where s2 != swi_clean and cnt == STABLE_CYCLES-1, swi_clean SHALL load s2 and cnt SHALL load 0.
REQ-016 Latency: if swi_raw is stable before sampling edge 0, swi_clean SHALL change exactly after edge STABLE_CYCLES+1 and not earlier.
REQ-017 rise/fall SHALL be registered, high for exactly the one cycle following the swi_clean update, and 0 in every other cycle.
REQ-018 A bit SHALL never assert rise and fall in the same cycle.
REQ-019 Glitch rejection: any s2 deviation shorter than STABLE_CYCLES edges SHALL leave swi_clean unchanged and SHALL return cnt to 0.
REQ-020 Bounce: every return of s2 to the swi_clean value SHALL restart the count from 0, so acceptance occurs STABLE_CYCLES+1 edges after the last raw transition.
REQ-021 Bits SHALL be fully independent; simultaneous updates on several bits SHALL pulse in the same cycle.
REQ-022 The counter SHALL never wrap; any value above STABLE_CYCLES-1 is unreachable.
REQ-023 With STABLE_CYCLES == 1, swi_clean SHALL follow s2 one edge later.

Reset
REQ-024 While reset is high, the block SHALL force, asynchronously: s1 = s2 = RESET_VALUE, cnt = 0, swi_clean = RESET_VALUE, rise = fall = 0, changed = 0.
REQ-025 Reset asserted mid-count SHALL discard the partial count; after release, the count SHALL restart per REQ-016 from the first sampling edge.
REQ-026 No output SHALL pulse as a result of reset assertion or release alone.

Structure
REQ-027 NBITS_TOP (8) and the default debounce depth SHALL be defined in the shared package with the other NBITS_* constants, and swi_debouncer SHALL import them.
REQ-028 A one-bit sub-module debounce_bit (synchronizer, cnt, clean flop, edge pulses) SHALL be instantiated NBITS times with a generate loop; the top level SHALL contain only the generate loop and the changed reduction.

Verification (STABLE_CYCLES=4, RESET_VALUE=0)
REQ-029 Scenario: hold reset with swi_raw=8'hFF -> swi_clean=8'h00, rise/fall=0; release reset -> swi_clean=8'hFF after edge 5, rise=8'hFF for one cycle, changed=1 for one cycle.
REQ-030 Scenario: swi_raw[0] high for 3 cycles, then low -> swi_clean=8'h00 throughout, rise=0, changed=0.
REQ-031 Scenario: swi_raw toggles bit2 1,0,1,0,1 on successive cycles, then holds 1 -> swi_clean[2]=1 exactly 5 edges after the last toggle, single rise[2] pulse.
REQ-032 Scenario: from swi_clean=8'h40, set swi_raw=8'h08 in one cycle -> rise=8'h08 and fall=8'h40 in the same cycle, changed=1.
REQ-033 Scenario: swi_raw bit5 rises, reset pulses after 3 edges, then is released -> no pulse before release; rise[5] occurs 5 edges after release.

Source files
------------

// File: rtl/swi_debouncer_pkg.sv
// Shared constants for the switch/display slice: bank widths and debounce depth,
// plus the counter-width helper used by every debounce instance.
package swi_debouncer_pkg;

  localparam int NBITS_TOP       = 8;
  localparam int NBITS_LEDR      = 10;
  localparam int NBITS_HEX       = 7;
  localparam int DEBOUNCE_CYCLES = 4;

  // Width needed to hold 0..stable; never below one bit.
  function automatic int cnt_width(input int stable);
    return (stable < 1) ? 1 : $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/swi_debouncer_if.sv
// Switch-bank signal bundle: the raw switches going in and the debounced
// levels, edge pulses and change flag coming out.
interface swi_debouncer_if
  import swi_debouncer_pkg::*;
#(
  parameter int NBITS = NBITS_TOP
);
  logic [NBITS-1:0] swi_raw;
  logic [NBITS-1:0] swi_clean;
  logic [NBITS-1:0] rise;
  logic [NBITS-1:0] fall;
  logic             changed;

  modport master (output swi_raw, input swi_clean, rise, fall, changed);
  modport slave  (input swi_raw, output swi_clean, rise, fall, changed);
endinterface

// File: rtl/swi_debouncer_bit.sv
// One switch: two-flop synchronizer, run-length counter, clean level flop and
// registered rise/fall pulses. 'update' flags the edge on which clean changes.
module debounce_bit
  import swi_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEBOUNCE_CYCLES,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk_2,
  input  logic reset,
  input  logic swi_raw,
  output logic swi_clean,
  output logic rise,
  output logic fall,
  output logic update
);

  localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_d, s1_q;
  logic             s2_d, s2_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             clean_d, clean_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic             accept;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    s1_d    = swi_raw;
    s2_d    = s1_q;
    cnt_d   = '0;
    clean_d = clean_q;
    accept  = 1'b0;
    // Any sample agreeing with the clean level falls through with cnt_d = 0.
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        clean_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = accept & s2_q;
    fall_d = accept & ~s2_q;
  end

  // NOTE: the synchronizer flops are reset too, so release never looks like a switch edge.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so s1 -> s2 shifts, not collapses.
      s1_q    <= RESET_VALUE;
      s2_q    <= RESET_VALUE;
      cnt_q   <= '0;
      clean_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign swi_clean = clean_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign update    = accept;

endmodule

// File: rtl/swi_debouncer.sv
// Switch-bank debouncer: one independent debounce_bit per switch plus a
// registered 'changed' flag aligned with the rise/fall pulses.
module swi_debouncer
  import swi_debouncer_pkg::*;
#(
  parameter int               NBITS         = NBITS_TOP,
  parameter int               STABLE_CYCLES = DEBOUNCE_CYCLES,
  parameter logic [NBITS-1:0] RESET_VALUE   = '0
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_clean,
  output logic [NBITS-1:0] rise,
  output logic [NBITS-1:0] fall,
  output logic             changed
);

  logic [NBITS-1:0] update;
  logic             changed_d, changed_q;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_bit (
      .clk_2     (clk_2),
      .reset     (reset),
      .swi_raw   (swi_raw[i]),
      .swi_clean (swi_clean[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .update    (update[i])
    );
  end

  // Reduced from the pre-register accept flags so it lands with the pulses.
  always_comb changed_d = |update;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) changed_q <= 1'b0;
    else       changed_q <= changed_d;
  end

  assign changed = changed_q;

endmodule
